// File: rtl/rv_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and load/store.
// Data has priority; a consecutive-grant limit guarantees fetch progress.
module rv_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int MAX_DGRANT = 4
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic [DATA_W-1:0]   i_d_wdata,
   input  logic [DATA_W/8-1:0] i_d_be,
   output logic                o_d_gnt,
   output logic                o_d_rvalid,
   output logic [DATA_W-1:0]   o_d_rdata,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_be,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   // state  | meaning
   // S_IDLE | no transaction outstanding; any request is granted at once
   // S_BUSY | transaction outstanding; lat_cnt == 0 marks the return cycle

   localparam int BE_W  = DATA_W / 8;
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SC_W  = $clog2(MAX_DGRANT + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t            state, state_nxt;
   logic [LAT_W-1:0]  lat_cnt, lat_nxt;
   logic [SC_W-1:0]   starv_cnt, starv_nxt;
   logic              own_d, own_d_nxt;
   logic              own_we, own_we_nxt;
   logic              ret_cycle;
   logic              can_gnt;
   logic              fetch_pick;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= S_IDLE;
         lat_cnt   <= '0;
         starv_cnt <= '0;
         own_d     <= 1'b0;
         own_we    <= 1'b0;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_nxt;
         starv_cnt <= starv_nxt;
         own_d     <= own_d_nxt;
         own_we    <= own_we_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lat_nxt     = lat_cnt;
      starv_nxt   = starv_cnt;
      own_d_nxt   = own_d;
      own_we_nxt  = own_we;
      o_if_gnt    = 1'b0;
      o_if_rvalid = 1'b0;
      o_if_rdata  = '0;
      o_d_gnt     = 1'b0;
      o_d_rvalid  = 1'b0;
      o_d_rdata   = '0;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_be    = '0;

      ret_cycle  = i_rstn && (state == S_BUSY) && (lat_cnt == '0);
      // Grants are combinational, so they must be suppressed while reset is held.
      can_gnt    = i_rstn && ((state == S_IDLE) || ret_cycle);
      fetch_pick = i_if_req && (!i_d_req || (starv_cnt == SC_W'(MAX_DGRANT)));

      if ((state == S_BUSY) && (lat_cnt != '0))
         lat_nxt = lat_cnt - LAT_W'(1);

      if (ret_cycle) begin
         state_nxt = S_IDLE;
         if (own_d) begin
            o_d_rvalid = 1'b1;
            o_d_rdata  = own_we ? '0 : i_mem_rdata;
         end else begin
            o_if_rvalid = 1'b1;
            o_if_rdata  = i_mem_rdata;
         end
      end

      if (can_gnt && fetch_pick) begin
         o_if_gnt   = 1'b1;
         o_mem_en   = 1'b1;
         o_mem_addr = i_if_addr;
         o_mem_be   = {BE_W{1'b1}};
         own_d_nxt  = 1'b0;
         own_we_nxt = 1'b0;
         state_nxt  = S_BUSY;
         lat_nxt    = LAT_W'(MEM_LAT - 1);
      end else if (can_gnt && i_d_req) begin
         o_d_gnt     = 1'b1;
         o_mem_en    = 1'b1;
         o_mem_we    = i_d_we;
         o_mem_addr  = i_d_addr;
         o_mem_wdata = i_d_wdata;
         o_mem_be    = i_d_be;
         own_d_nxt   = 1'b1;
         own_we_nxt  = i_d_we;
         state_nxt   = S_BUSY;
         lat_nxt     = LAT_W'(MEM_LAT - 1);
      end

      if (!i_if_req || o_if_gnt)
         starv_nxt = '0;
      else if (o_d_gnt && (starv_cnt != SC_W'(MAX_DGRANT)))
         starv_nxt = starv_cnt + SC_W'(1);
   end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port. It is intended for the SoC build, where instruction and data memories are merged.
- Sequences one memory transaction at a time.
- Routes the read data back to the port that issued the transaction.
- Gives data accesses priority, with a starvation guard so fetch always makes progress.

Parameters:
ADDR_W, 32, address width of both ports and the memory.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
MEM_LAT, 1, number of clock edges from memory command to valid i_mem_rdata; must be >= 1.
MAX_DGRANT, 4, maximum consecutive data grants while fetch is waiting before fetch is forced.

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_if_req  in  1  fetch request; held with address until granted
i_if_addr  in  ADDR_W  fetch address
o_if_gnt  out  1  fetch request accepted this cycle
o_if_rvalid  out  1  fetch read data valid (1-cycle pulse)
o_if_rdata  out  DATA_W  fetch read data
i_d_req  in  1  data request; held with its fields until granted
i_d_we  in  1  1 = write, 0 = read
i_d_addr  in  ADDR_W  data address
i_d_wdata  in  DATA_W  write data
i_d_be  in  DATA_W/8  byte enables
o_d_gnt  out  1  data request accepted this cycle
o_d_rvalid  out  1  data completion pulse (reads and writes)
o_d_rdata  out  DATA_W  data read data; 0 on write completion
o_mem_en  out  1  memory command strobe
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
o_mem_be  out  DATA_W/8  memory byte enables
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT edges after command

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; lat counter = 0; starvation counter = 0; owner register cleared.
  - All outputs go to 0. No rvalid is ever produced for a transaction cut off by reset.
- State machine:
  - IDLE: if any request is present, arbitrate. Grant and the memory command are combinational in the same cycle. Move to BUSY with lat counter = MEM_LAT-1 and owner recorded.
  - BUSY: lat counter decrements each cycle; no grant is issued.
  - When lat counter = 0 (the return cycle):
    - The owner's rvalid is 1.
    - Owner rdata = i_mem_rdata for a read, 0 for a write.
    - The arbiter may grant a new request in this same cycle.
      - If it does, stay BUSY with lat counter reloaded.
      - Otherwise go to IDLE.
- Timing consequences:
  - A grant at cycle T produces rvalid at cycle T+MEM_LAT.
  - Throughput is one transaction per MEM_LAT cycles. With MEM_LAT = 1, a grant can occur every cycle.
- Arbitration:
  - Data wins over fetch by default.
  - If the starvation counter = MAX_DGRANT and i_if_req = 1, fetch wins.
  - Starvation counter increments on each data grant made while i_if_req = 1, saturating at MAX_DGRANT.
  - Starvation counter clears on any fetch grant, and in any cycle with i_if_req = 0.
- Memory command:
  - o_mem_en = 1 only in grant cycles.
  - Fetch commands drive we = 0, be = all ones, wdata = 0.
  - Data commands pass we, be and wdata through from the data port.
  - All memory outputs are 0 when o_mem_en = 0.
- Gating:
  - At most one gnt per cycle, and at most one rvalid per cycle.
  - rvalid outputs are 0 outside return cycles. rdata outputs are 0 when the matching rvalid = 0.
  - Requests dropped before being granted are ignored; there is no state effect.

Test Plan:
- Reset: hold i_rstn = 0 with both requests high -> every output = 0, no gnt. After release with no requests -> outputs stay 0.
- Fetch stream, MEM_LAT = 1, fetch addresses 0x0, 0x4, 0x8; memory returns addr+0x1000 -> o_if_gnt high for 3 consecutive cycles; o_if_rvalid high on the next 3 cycles with rdata 0x1000, 0x1004, 0x1008.
- Simultaneous requests: fetch 0x20 and data read 0x100 in the same cycle -> o_d_gnt first (mem_addr 0x100); o_if_gnt the next cycle (mem_addr 0x20); o_d_rvalid precedes o_if_rvalid.
- Starvation, MAX_DGRANT = 4: continuous data requests with fetch held -> grant order D, D, D, D, F, D; starvation counter back to 0 after the F grant.
- MEM_LAT = 3, both requests held -> grants only at T, T+3, T+6; rvalid at T+3, T+6; no gnt at T+1, T+2.
- Write then reset:
  - Data write to 0x100, wdata 0xDEADBEEF, be 0011 -> grant cycle shows mem_we = 1, be = 0011, wdata 0xDEADBEEF; o_d_rvalid at T+1 with rdata 0.
  - With MEM_LAT = 3, assert reset at T+1 -> no rvalid ever appears; state is IDLE after release.
